calc_ctrl: RTL and testbench
============================

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low; the block has one clock.
REQ-004 SHALL have port in_valid  input  1  token offered.
REQ-005 SHALL have port in_ready  output  1  token accepted when in_valid & in_ready at a rising edge.
REQ-006 SHALL have port in_kind  input  2  token type: 00 operand, 01 op, 10 equals, 11 clear.
REQ-007 SHALL have port in_data  input  WIDTH  operand value (kind 00) or op code in in_data[2:0] (kind 01); ignored otherwise.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  result consumed when res_valid & res_ready at a rising edge.
REQ-010 SHALL have port res_data  output  WIDTH  registered ALU result.
REQ-011 SHALL have port err  output  1  one-cycle pulse on an illegal token.

Function
REQ-012 SHALL implement FSM states IDLE, GOT_A, GOT_OP, GOT_B, EXEC, DONE.
REQ-013 SHALL drive in_ready=1 in IDLE, GOT_A, GOT_OP, GOT_B and 0 in EXEC, DONE.
REQ-014 SHALL accept a clear token in any ready state: go to IDLE, zero A, B, op; err stays 0.
REQ-015 SHALL handle IDLE: operand loads A and goes to GOT_A; op or equals is illegal.
REQ-016 SHALL handle GOT_A: operand overwrites A; op loads op and goes to GOT_OP; equals is illegal.
REQ-017 SHALL handle GOT_OP for binary op (000-100, 111): operand loads B and goes to GOT_B; op overwrites op; equals is illegal.
REQ-018 SHALL handle GOT_OP for unary op (101 NOT A, 110 PASS A): equals goes to EXEC with B ignored; operand loads B and goes to GOT_B; op overwrites op.
REQ-019 SHALL handle GOT_B: operand overwrites B; equals goes to EXEC; op is illegal.
REQ-020 SHALL consume an illegal token (in_ready high), leave the state and registers unchanged, and pulse err high for exactly the cycle after acceptance.
REQ-021 SHALL, in EXEC, capture the ALU result into res_data at the next rising edge, set res_valid=1 and go to DONE; equals accepted at edge k gives res_valid=1 after edge k+1.
REQ-022 SHALL, in DONE, hold res_valid and res_data stable until res_ready; on the handshake edge, clear res_valid, copy res_data into A and go to GOT_A (chaining).
REQ-023 SHALL allow res_ready high on the capture edge to take no effect; the handshake occurs no earlier than the edge after res_valid rises.
REQ-024 SHALL take arithmetic from the ALU: ADD/SUB wrap modulo 2^WIDTH, with no carry or borrow output.
REQ-025 SHALL drive the ALU operands from the A, B and op registers only; they are stable throughout EXEC.
REQ-026 SHALL ignore in_data when in_kind is 10 or 11.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, A=B=op=0, res_data=0, res_valid=0, err=0 and in_ready=0, asynchronously.
REQ-028 SHALL raise in_ready on the first rising edge after rst_n deasserts, with no token accepted on that edge.
REQ-029 SHALL, on reset during EXEC or DONE, abandon the pending result with no res_valid pulse after reset release.

Structure
REQ-030 SHALL place the op codes (ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101, PASSA 110, PASSB 111), token kinds and the FSM state enum in shared package calc_pkg.
REQ-031 SHALL instantiate the existing alu module (A, B, sel, result) as its single sub-module; all other logic stays inline.

Verification
REQ-032 SHALL cover: tokens 0101, op ADD, 0011, equals -> res_valid after edge k+1, res_data=1000, err=0.
REQ-033 SHALL cover: after 0101 SUB 0011 = gives 0010 and res_ready=1, tokens op ADD, 1111, equals -> res_data=0001 (wrap).
REQ-034 SHALL cover: 0101, op NOT, equals -> res_data=1010, with no B token needed.
REQ-035 SHALL cover: op token in IDLE, then equals in GOT_A -> err pulses twice, one cycle each, and the state is unchanged each time.
REQ-036 SHALL cover: res_ready held 0 for 5 cycles in DONE -> res_valid=1, res_data stable, in_ready=0 throughout; then the handshake moves to GOT_A.
REQ-037 SHALL cover: rst_n pulsed low during EXEC -> all outputs 0 immediately, no res_valid afterwards, and a fresh 0001 AND 0011 = gives 0001.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_ctrl token calculator.
//   op_e    : 3-bit ALU op codes carried in in_data[2:0] of an op token
//   kind_e  : 2-bit token kinds carried on in_kind
//   state_e : controller FSM states
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_NOT   = 3'b101,
        OP_PASSA = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        K_OPND  = 2'b00,
        K_OP    = 2'b01,
        K_EQ    = 2'b10,
        K_CLR   = 2'b11
    } kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_A,
        S_GOT_OP,
        S_GOT_B,
        S_EXEC,
        S_DONE
    } state_e;

    // Unary ops only read A, so equals may follow the op directly.
    function automatic logic is_unary(op_e op);
        return (op == OP_NOT) || (op == OP_PASSA);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU used by calc_ctrl.
//   A, B   : operands
//   sel    : op code (calc_pkg::op_e)
//   result : WIDTH-bit result; ADD/SUB wrap modulo 2^WIDTH, no carry out
module alu
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  op_e              sel,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (sel)
            OP_ADD:   result = A + B;
            OP_SUB:   result = A - B;
            OP_AND:   result = A & B;
            OP_OR:    result = A | B;
            OP_XOR:   result = A ^ B;
            OP_NOT:   result = ~A;
            OP_PASSA: result = A;
            OP_PASSB: result = B;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/calc_ctrl.sv
// Token-driven calculator controller. Collects operand A, an op, operand B
// (skipped for unary ops), executes on an equals token and presents the
// result through a valid/ready handshake. A consumed result becomes the new
// A so expressions can be chained.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : token handshake
//   in_kind, in_data    : token type and payload
//   res_valid/res_ready : result handshake
//   res_data            : registered ALU result
//   err                 : one-cycle pulse after an illegal token is accepted
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [WIDTH-1:0] in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             err
);

    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    op_e              r_op;
    logic             r_res_valid, r_err;
    // Low through reset and the first edge after release, so no token can
    // be accepted on the release edge.
    logic             r_up;

    kind_e            w_kind;
    logic             w_acc;
    logic             w_ld_a, w_ld_b, w_ld_op, w_clr, w_illegal, w_cap, w_hs;
    logic [WIDTH-1:0] w_alu;

    assign w_kind = kind_e'(in_kind);
    assign w_acc  = in_valid & in_ready;

    alu #(.WIDTH(WIDTH)) u_alu (
        .A      (r_a),
        .B      (r_b),
        .sel    (r_op),
        .result (w_alu)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and datapath strobes
    always_comb begin
        w_next    = r_state;
        w_ld_a    = 1'b0;
        w_ld_b    = 1'b0;
        w_ld_op   = 1'b0;
        w_clr     = 1'b0;
        w_illegal = 1'b0;
        w_cap     = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_cap  = 1'b1;
                w_next = S_DONE;
            end
            // res_valid is always high here, so res_ready alone completes it
            S_DONE: begin
                if (res_ready) begin
                    w_hs   = 1'b1;
                    w_next = S_GOT_A;
                end
            end
            default: begin
                if (w_acc) begin
                    if (w_kind == K_CLR) begin
                        w_clr  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        case (r_state)
                            S_IDLE: begin
                                if (w_kind == K_OPND) begin
                                    w_ld_a = 1'b1;
                                    w_next = S_GOT_A;
                                end else w_illegal = 1'b1;
                            end
                            S_GOT_A: begin
                                case (w_kind)
                                    K_OPND: w_ld_a = 1'b1;
                                    K_OP: begin
                                        w_ld_op = 1'b1;
                                        w_next  = S_GOT_OP;
                                    end
                                    default: w_illegal = 1'b1;
                                endcase
                            end
                            S_GOT_OP: begin
                                case (w_kind)
                                    K_OPND: begin
                                        w_ld_b = 1'b1;
                                        w_next = S_GOT_B;
                                    end
                                    K_OP: w_ld_op = 1'b1;
                                    K_EQ: begin
                                        if (is_unary(r_op)) w_next = S_EXEC;
                                        else                w_illegal = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            S_GOT_B: begin
                                case (w_kind)
                                    K_OPND:  w_ld_b = 1'b1;
                                    K_EQ:    w_next = S_EXEC;
                                    default: w_illegal = 1'b1;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B: in_ready = r_up;
            default:                            in_ready = 1'b0;
        endcase
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res;
    assign err       = r_err;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_up        <= 1'b0;
        end else begin
            r_up  <= 1'b1;
            r_err <= w_illegal;
            if (w_clr) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= OP_ADD;
            end
            if (w_ld_a)  r_a  <= in_data;
            if (w_hs)    r_a  <= r_res;
            if (w_ld_b)  r_b  <= in_data;
            if (w_ld_op) r_op <= op_e'(in_data[2:0]);
            if (w_cap) begin
                r_res       <= w_alu;
                r_res_valid <= 1'b1;
            end
            if (w_hs) r_res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl (WIDTH=4): directed token sequences, a
// behavioural model compared every falling edge, plus literal expectations.
module tb_calc_ctrl;

    localparam logic [1:0] KOPND = 2'b00, KOP = 2'b01, KEQ = 2'b10, KCLR = 2'b11;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, XOR_ = 4'd4, NOT_ = 4'd5, PASSA = 4'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_kind = 2'b00;
    logic [3:0] in_data = 4'h0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic       err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    calc_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err       (err)
    );

    // ---------------- behavioural model ----------------
    // stage: 0 nothing held, 1 have A, 2 have op, 3 have B, 4 computing, 5 result waiting
    typedef struct {
        logic [3:0] a, b, res;
        logic [2:0] op;
        int         stage;
        logic       rv, err, up;
    } mdl_t;

    mdl_t m;

    function automatic logic [3:0] calc(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        case (op)
            3'd0:    return 4'((int'(a) + int'(b)) % 16);
            3'd1:    return 4'((int'(a) - int'(b) + 16) % 16);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return 4'(15 - int'(a));
            3'd6:    return a;
            default: return b;
        endcase
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.a = 0; n.b = 0; n.res = 0; n.op = 0; n.stage = 0;
        n.rv = 0; n.err = 0; n.up = 0;
        return n;
    endfunction

    function automatic mdl_t step(mdl_t cur, logic v, logic [1:0] k, logic [3:0] d, logic rr);
        mdl_t n;
        logic acc;
        n = cur;
        n.err = 0;
        n.up = 1;
        acc = v && cur.up && (cur.stage < 4);
        if (cur.stage == 4) begin
            n.res = calc(cur.op, cur.a, cur.b);
            n.rv = 1;
            n.stage = 5;
        end else if (cur.stage == 5) begin
            if (rr) begin
                n.a = cur.res;
                n.rv = 0;
                n.stage = 1;
            end
        end else if (acc) begin
            if (k == KCLR) begin
                n.a = 0; n.b = 0; n.op = 0; n.stage = 0;
            end else if (k == KOPND) begin
                if (cur.stage <= 1) begin n.a = d; n.stage = 1; end
                else begin n.b = d; n.stage = 3; end
            end else if (k == KOP) begin
                if (cur.stage == 1 || cur.stage == 2) begin n.op = d[2:0]; n.stage = 2; end
                else n.err = 1;
            end else begin
                if (cur.stage == 3 || (cur.stage == 2 && (cur.op == 3'd5 || cur.op == 3'd6)))
                    n.stage = 4;
                else
                    n.err = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else        m <= step(m, in_valid, in_kind, in_data, res_ready);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        chk("mdl_in_ready",  8'(in_ready),  8'(m.up && (m.stage < 4)));
        chk("mdl_res_valid", 8'(res_valid), 8'(m.rv));
        chk("mdl_res_data",  8'(res_data),  8'(m.res));
        chk("mdl_err",       8'(err),       8'(m.err));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [3:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_kind  = k;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("consume_valid_low", 8'(res_valid), 8'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_res_valid", 8'(res_valid), 8'd0);
        chk("rst_res_data", 8'(res_data), 8'd0);
        chk("rst_err", 8'(err), 8'd0);

        // release with an operand already offered: it must not be taken
        in_valid = 1'b1; in_kind = KOPND; in_data = 4'hF;
        rst_n = 1'b1;
        #1 chk("rel_in_ready_low", 8'(in_ready), 8'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 4'h0;
        chk("rel_in_ready_high", 8'(in_ready), 8'd1);

        // illegal op in IDLE, then illegal equals in GOT_A
        send(KOP, ADD);
        chk("err_idle_op", 8'(err), 8'd1);
        tick();
        chk("err_idle_op_end", 8'(err), 8'd0);
        send(KOPND, 4'b0101);
        send(KEQ, 4'h0);
        chk("err_gota_eq", 8'(err), 8'd1);
        tick();
        chk("err_gota_eq_end", 8'(err), 8'd0);

        // 0101 + 0011 = 1000, result one edge after equals
        send(KOP, ADD);
        send(KOPND, 4'b0011);
        send(KEQ, 4'h0);
        chk("exec_not_valid", 8'(res_valid), 8'd0);
        chk("exec_not_ready", 8'(in_ready), 8'd0);
        tick();
        chk("add_valid", 8'(res_valid), 8'd1);
        chk("add_data", 8'(res_data), 8'b1000);
        chk("add_err", 8'(err), 8'd0);

        // hold in DONE for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 8'(res_valid), 8'd1);
            chk("hold_data", 8'(res_data), 8'b1000);
            chk("hold_in_ready", 8'(in_ready), 8'd0);
        end
        consume();
        chk("hs_in_ready", 8'(in_ready), 8'd1);

        // chained A=1000, PASSA is unary
        send(KOP, PASSA);
        send(KEQ, 4'h0);
        tick();
        chk("chain_passa", 8'(res_data), 8'b1000);
        consume();

        // 0101 - 0011 = 0010, res_ready high on capture edge has no effect
        send(KCLR, 4'hA);
        send(KOPND, 4'b0101);
        send(KOP, SUB);
        send(KOPND, 4'b0011);
        send(KEQ, 4'h0);
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1;
        chk("sub_capture_valid", 8'(res_valid), 8'd1);
        chk("sub_data", 8'(res_data), 8'b0010);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("sub_consumed", 8'(res_valid), 8'd0);
        // chained 0010 + 1111 wraps to 0001; op in GOT_B is illegal
        send(KOP, ADD);
        send(KOPND, 4'b1111);
        send(KOP, XOR_);
        chk("err_gotb_op", 8'(err), 8'd1);
        send(KEQ, 4'h0);
        tick();
        chk("wrap_data", 8'(res_data), 8'b0001);
        consume();

        // NOT 0101 = 1010 without a B token
        send(KCLR, 4'h0);
        send(KOPND, 4'b0101);
        send(KOP, NOT_);
        send(KEQ, 4'h0);
        tick();
        chk("not_data", 8'(res_data), 8'b1010);
        chk("not_err", 8'(err), 8'd0);
        consume();

        // reset while in EXEC abandons the result
        send(KCLR, 4'h0);
        send(KOPND, 4'b0101);
        send(KOP, ADD);
        send(KOPND, 4'b0011);
        send(KEQ, 4'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rstx_in_ready", 8'(in_ready), 8'd0);
        chk("rstx_res_valid", 8'(res_valid), 8'd0);
        chk("rstx_res_data", 8'(res_data), 8'd0);
        chk("rstx_err", 8'(err), 8'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstx_no_valid", 8'(res_valid), 8'd0);
        end
        send(KOPND, 4'b0001);
        send(KOP, AND_);
        send(KOPND, 4'b0011);
        send(KEQ, 4'h0);
        tick();
        chk("and_valid", 8'(res_valid), 8'd1);
        chk("and_data", 8'(res_data), 8'b0001);
        consume();

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
